// File: rtl/conv_mac_unit.sv
// conv_mac_unit: multiply-accumulate stage behind the convolution controller.
// Each cycle it can latch one pixel x weight product. It accumulates KSIZE
// products per window, then requantizes the sum (arithmetic shift right plus
// saturation) and writes the result to the output memory at an address that
// advances by itself.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   frame_start   - one-cycle pulse: restart output address, clear done
//   pix_in, kr_in - signed pixel / weight pair
//   en_mult       - load product register
//   en_accuml     - add product register into accumulator
//   rst_accuml    - clear accumulator and window state
//   accu_shift    - requantize shift amount
//   out_data      - saturated result
//   out_addr      - output memory write address
//   en_out_mem, rw_out_mem, valid - one-cycle write strobe (all identical)
//   done          - sticky frame-complete flag
module conv_mac_unit #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int KSIZE      = 9,
  parameter int OUT_DEPTH  = 16,
  parameter int OUT_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic [DATA_W-1:0]     kr_in,
  input  logic                  en_mult,
  input  logic                  en_accuml,
  input  logic                  rst_accuml,
  input  logic [4:0]            accu_shift,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic                  en_out_mem,
  output logic                  rw_out_mem,
  output logic                  valid,
  output logic                  done
);

  localparam int CNT_W = $clog2(KSIZE + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [2*DATA_W-1:0] prod_r;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_shr;
  logic [CNT_W-1:0]           tap_cnt;
  logic [CNT_W-1:0]           tap_next;
  logic                       pending;
  logic                       pend_next;
  logic                       emit;
  logic [DATA_W-1:0]          sat_val;

  always_comb begin
    prod_ext = {{(ACC_W - 2*DATA_W){prod_r[2*DATA_W-1]}}, prod_r};
    // A shift of ACC_W or more fills with the sign bit, giving 0 or -1.
    acc_shr  = acc >>> accu_shift;
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = acc_shr[DATA_W-1:0];
  end

  // Window control. rst_accuml outranks the emit; on an emit edge the
  // accumulator reloads directly from prod_r so back-to-back windows drop
  // no product.
  always_comb begin
    acc_next = acc;
    tap_next = tap_cnt;
    emit     = 1'b0;
    if (rst_accuml) begin
      acc_next = en_accuml ? prod_ext : '0;
      tap_next = en_accuml ? CNT_W'(1) : '0;
    end else if (pending) begin
      emit     = 1'b1;
      acc_next = en_accuml ? prod_ext : '0;
      tap_next = en_accuml ? CNT_W'(1) : '0;
    end else if (en_accuml) begin
      acc_next = acc + prod_ext;
      tap_next = tap_cnt + 1'b1;
    end
    pend_next = en_accuml && (tap_next == CNT_W'(KSIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r     <= '0;
      acc        <= '0;
      tap_cnt    <= '0;
      pending    <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      en_out_mem <= 1'b0;
      rw_out_mem <= 1'b0;
      valid      <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (en_mult) prod_r <= $signed(pix_in) * $signed(kr_in);
      acc        <= acc_next;
      tap_cnt    <= tap_next;
      pending    <= pend_next;
      en_out_mem <= emit;
      rw_out_mem <= emit;
      valid      <= emit;
      if (emit) out_data <= sat_val;
      // The address advances on the edge that ends the write cycle.
      if (frame_start) begin
        out_addr <= '0;
        done     <= 1'b0;
      end else if (valid) begin
        if (out_addr == OUT_ADDR_W'(OUT_DEPTH - 1)) begin
          out_addr <= '0;
          done     <= 1'b1;
        end else begin
          out_addr <= out_addr + 1'b1;
        end
      end
    end
  end

endmodule
